// File: rtl/uart_pkg.sv
// Shared types and constants for the UART packet receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  localparam logic [1:0] DROP_LEN     = 2'd0;
  localparam logic [1:0] DROP_CSUM    = 2'd1;
  localparam logic [1:0] DROP_RXERR   = 2'd2;
  localparam logic [1:0] DROP_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/rollback_fifo.sv
// FIFO with a speculative write pointer: bytes become visible to the reader
// only after commit, and rewind throws away everything written since the
// last commit without touching the read side.
module rollback_fifo #(
  parameter int DEPTH = 32,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [8:0]    wr_data,
  input  logic          commit,
  input  logic          rewind,
  input  logic          rd_en,
  output logic [8:0]    rd_data,
  output logic          rd_valid,
  output logic [PW-1:0] free
);

  logic [8:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_commitPtr;
  logic [PW-1:0] r_rdPtr;
  logic          w_wr;
  logic          w_rd;

  assign w_wr     = wr_en && !rewind;
  assign rd_valid = (r_rdPtr != r_commitPtr);
  assign w_rd     = rd_en && rd_valid;
  assign rd_data  = rd_valid ? r_mem[r_rdPtr[PW-2:0]] : 9'd0;
  assign free     = PW'(DEPTH) - (r_wrPtr - r_rdPtr);

  // Pointer bookkeeping: rewind snaps the write pointer back to the last commit point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr     <= '0;
      r_commitPtr <= '0;
      r_rdPtr     <= '0;
    end else begin
      if (rewind) begin
        r_wrPtr <= r_commitPtr;
      end else if (w_wr) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (commit) begin
        r_commitPtr <= r_wrPtr;
      end
      if (w_rd) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // Storage array; contents are only observable through committed pointers.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wrPtr[PW-2:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: parses SOF/LEN/payload/CSUM,
// buffers payload speculatively and releases it only on a good checksum.
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         MAX_LEN = 16,
  parameter int         DEPTH   = 32,
  parameter int         TIMEOUT = 100000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       pkt_ok,
  output logic       pkt_drop,
  output logic [1:0] drop_code,
  output logic       busy
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t        r_state;
  state_t        w_nextState;
  logic [7:0]    r_remain;
  logic [7:0]    r_acc;
  logic [TW-1:0] r_tmo;
  logic          r_pktOk;
  logic          r_pktDrop;
  logic [1:0]    r_dropCode;

  logic          w_err;
  logic          w_tmo;
  logic          w_byte;
  logic          w_wr;
  logic          w_commit;
  logic          w_drop;
  logic          w_ok;
  logic [1:0]    w_code;
  logic [7:0]    w_sum;
  logic          w_lenBad;
  logic [PW-1:0] w_free;
  logic [8:0]    w_rdData;
  logic          w_rdValid;

  assign w_err    = rx_error && (r_state != ST_IDLE);
  assign w_tmo    = (r_state != ST_IDLE) && (r_tmo == TW'(TIMEOUT - 1));
  assign w_byte   = rx_valid && !w_err && !w_tmo;
  assign w_sum    = r_acc + rx_data;
  assign w_lenBad = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN)) ||
                    ({1'b0, rx_data} > 9'(w_free));

  // Parser next-state: receiver error beats timeout, which beats byte handling.
  always_comb begin
    w_nextState = r_state;
    w_drop      = 1'b0;
    w_code      = DROP_LEN;
    w_ok        = 1'b0;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    if (w_err) begin
      w_drop = 1'b1;
      w_code = DROP_RXERR;
    end else if (w_tmo) begin
      w_drop = 1'b1;
      w_code = DROP_TIMEOUT;
    end else if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SOF) w_nextState = ST_LEN;
        end
        ST_LEN: begin
          if (w_lenBad) begin
            w_drop = 1'b1;
            w_code = DROP_LEN;
          end else begin
            w_nextState = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_wr = 1'b1;
          if (r_remain == 8'd1) w_nextState = ST_CSUM;
        end
        default: begin
          if (w_sum == 8'd0) begin
            w_commit    = 1'b1;
            w_ok        = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_drop = 1'b1;
            w_code = DROP_CSUM;
          end
        end
      endcase
    end
    if (w_drop) w_nextState = ST_IDLE;
  end

  // Parser state register.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nextState;
  end

  // Length/checksum tracking, inter-byte timeout and registered status pulses.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_remain   <= 8'd0;
      r_acc      <= 8'd0;
      r_tmo      <= '0;
      r_pktOk    <= 1'b0;
      r_pktDrop  <= 1'b0;
      r_dropCode <= DROP_LEN;
    end else begin
      if (w_byte && r_state == ST_LEN) begin
        r_remain <= rx_data;
        r_acc    <= rx_data;
      end else if (w_byte && r_state == ST_PAYLOAD) begin
        r_remain <= r_remain - 8'd1;
        r_acc    <= w_sum;
      end
      if (r_state == ST_IDLE || rx_valid) r_tmo <= '0;
      else                                r_tmo <= r_tmo + 1'b1;
      r_pktOk   <= w_ok;
      r_pktDrop <= w_drop;
      if (w_drop) r_dropCode <= w_code;
    end
  end

  rollback_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (rst),
    .wr_en    (w_wr),
    .wr_data  ({(r_remain == 8'd1), rx_data}),
    .commit   (w_commit),
    .rewind   (w_drop),
    .rd_en    (m_ready),
    .rd_data  (w_rdData),
    .rd_valid (w_rdValid),
    .free     (w_free)
  );

  assign m_data    = w_rdData[7:0];
  assign m_last    = w_rdData[8];
  assign m_valid   = w_rdValid;
  assign pkt_ok    = r_pktOk;
  assign pkt_drop  = r_pktDrop;
  assign drop_code = r_dropCode;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_pkt_ctrl.md
# uart_rx_pkt_ctrl

Packet-level controller behind the UART receiver FSM. It takes the receiver's byte strobes (`data_out`/`error`), frames them as `SOF, LEN, payload[LEN], CSUM`, and buffers the payload in a rollback FIFO. A packet's payload is released to the downstream consumer only after its checksum passes; a failed packet is discarded as a whole. Runs in the `sys_clk` domain next to the receiver `fsm` inside `top`.

## Interface
- `SOF`, 8'hA5, start-of-frame byte
- `MAX_LEN`, 16, largest legal LEN (1..255)
- `DEPTH`, 32, FIFO entries; power of 2, ≥ MAX_LEN
- `TIMEOUT`, 100000, inter-byte timeout in sys_clk cycles (≥ 2)

- `sys_clk` in 1: system clock, all logic rising-edge
- `rst` in 1: asynchronous, active-low reset
- `rx_data` in 8: received byte from the receiver FSM
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid
- `rx_error` in 1: one-cycle framing-error strobe from the receiver
- `m_data` out 8: payload byte
- `m_last` out 1: `m_data` is the final byte of its packet
- `m_valid` out 1: committed byte available
- `m_ready` in 1: consumer accepts; a transfer occurs when `m_valid & m_ready`
- `pkt_ok` out 1: one-cycle pulse, packet committed
- `pkt_drop` out 1: one-cycle pulse, packet discarded
- `drop_code` out 2: reason, valid with `pkt_drop`. Codes: 0 = LEN (zero, > MAX_LEN, or no FIFO room); 1 = CSUM; 2 = RXERR; 3 = TIMEOUT
- `busy` out 1: FSM not in IDLE

## Operation
- **FSM: IDLE → LEN → PAYLOAD → CSUM → IDLE.**
  - IDLE: a byte equal to SOF moves to LEN. Any other byte, and any `rx_error`, is ignored silently.
  - LEN: the byte is loaded into `remain` and the checksum accumulator. The packet is dropped with code 0 if LEN == 0, LEN > MAX_LEN, or LEN > DEPTH − (wr_ptr − rd_ptr). Otherwise → PAYLOAD.
  - PAYLOAD: each byte is written at `wr_ptr` together with a last flag (set when `remain == 1`), added to the accumulator, and `remain` decrements. → CSUM after the last byte.
  - CSUM: if (acc + byte) mod 256 == 0, set `commit_ptr ← wr_ptr` and pulse `pkt_ok`. Otherwise `wr_ptr ← commit_ptr` and drop with code 1.
- Checksum: 8-bit wrapping sum of LEN, the payload bytes and CSUM must equal 8'h00.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Relations: `rd_ptr ≤ commit_ptr ≤ wr_ptr` (modular); full when `wr_ptr − rd_ptr == DEPTH`.
- Read side sees committed data only: `m_valid = (rd_ptr != commit_ptr)`. `m_data`/`m_last` come from `mem[rd_ptr]` (show-ahead), and `rd_ptr` increments on each transfer.
- Any drop: `wr_ptr ← commit_ptr`, FSM → IDLE. The read side is never disturbed.
- `rx_error` outside IDLE: drop code 2. If `rx_error` and `rx_valid` arrive in the same cycle, the error wins and the byte is discarded.
- Timeout counter: cleared on every `rx_valid` and while in IDLE, increments otherwise. Reaching TIMEOUT−1 outside IDLE drops with code 3.
- Priority within a cycle: rx_error > timeout > byte processing.

## Timing
- Reset values: `m_valid`, `m_last`, `pkt_ok`, `pkt_drop`, `busy` = 0; `drop_code` = 0; `m_data` = 0 (FIFO empty); state IDLE; all pointers, accumulator and counters = 0. All outputs are registered or decoded from registers.
- `pkt_ok` pulses the cycle after the CSUM strobe. `m_valid` rises in that same cycle.
- `pkt_drop` and `drop_code` appear the cycle after the offending strobe or timeout. `wr_ptr` is rewound in that same edge.
- Read throughput is 1 byte/cycle while `m_ready` is held high. `m_data` is stable while `m_valid & !m_ready`.
- A commit and a read may occur in the same cycle; both take effect.
- Reset asserted mid-packet or mid-read: all state is cleared asynchronously and buffered data is lost.

## Structure
- Shared package `uart_pkg`: state enum (`ST_IDLE`, `ST_LEN`, `ST_PAYLOAD`, `ST_CSUM`), drop-code constants (`DROP_LEN`, `DROP_CSUM`, `DROP_RXERR`, `DROP_TIMEOUT`), default SOF constant.
- Sub-module `rollback_fifo`: 9-bit wide, DEPTH deep, with `commit`/`rewind` inputs and `free` count output. The parser FSM, accumulator and timeout counter stay in the top level.

## Test plan
- Good packet: A5 03 11 22 33 97 with `m_ready`=1 → `pkt_ok` once; out 11, 22, 33; `m_last` on 33.
- Bad checksum: A5 02 10 20 00 → `pkt_drop`, code 1; `m_valid` stays 0; a following good packet is delivered intact.
- Bad length: A5 00, then separately A5 11 (MAX_LEN=16) → two drops with code 0. Junk byte 5A in IDLE → no pulse.
- Rollback: commit packet P1 (4 bytes) with `m_ready`=0, then send P2 with a bad CSUM → only P1's 4 bytes are readable, with `m_last` on byte 4.
- Backpressure/full: DEPTH=32; commit two 16-byte packets with `m_ready`=0, then send a third A5 01 … → drop code 0. Raise `m_ready` → 32 bytes drain in order.
- Error and timeout: `rx_error` during PAYLOAD → code 2. Stall TIMEOUT cycles after LEN → code 3 and `busy`=0. Async `rst` mid-PAYLOAD → all outputs 0 immediately.
